// File: rtl/multi_bank_buffer_control.sv
// multi_bank_buffer_control: ring of NUM_BANKS buffer banks, filled in order
// and read RD_PASSES times each before the bank is released back to the producer.
module multi_bank_buffer_control #(
    parameter int NUM_BANKS = 2,
    parameter int BANK_W    = 1,
    parameter int ADDR_SIZE = 4,
    parameter int DEPTH     = 16,
    parameter int RD_PASSES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    output logic [NUM_BANKS-1:0]        wr_en,
    output logic [BANK_W-1:0]           wr_bank,
    output logic [ADDR_SIZE-1:0]        wr_addr,
    input  logic                        rd_req,
    output logic                        rd_valid,
    output logic [NUM_BANKS-1:0]        rd_en,
    output logic [BANK_W-1:0]           rd_bank,
    output logic [ADDR_SIZE-1:0]        rd_addr,
    output logic [BANK_W+ADDR_SIZE-1:0] rd_pass,
    output logic [BANK_W:0]             fill_count,
    output logic                        wr_bank_done,
    output logic                        rd_bank_done
);
    localparam logic [BANK_W-1:0]           LAST_BANK = BANK_W'(NUM_BANKS - 1);
    localparam logic [BANK_W:0]             FULL      = (BANK_W+1)'(NUM_BANKS);
    localparam logic [ADDR_SIZE-1:0]        LAST_ADDR = ADDR_SIZE'(DEPTH - 1);
    localparam logic [BANK_W+ADDR_SIZE-1:0] LAST_PASS = (BANK_W+ADDR_SIZE)'(RD_PASSES - 1);

    logic wr_fire, rd_fire, rd_wrap, commit, rel;

    assign wr_ready = !rst && fill_count < FULL;
    assign rd_valid = !rst && fill_count != '0;
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_req && rd_valid;
    assign rd_wrap  = rd_fire && rd_addr == LAST_ADDR;
    assign commit   = wr_fire && wr_addr == LAST_ADDR;
    assign rel      = rd_wrap && rd_pass == LAST_PASS;
    assign wr_en    = wr_fire ? NUM_BANKS'(1) << wr_bank : '0;
    assign rd_en    = rd_fire ? NUM_BANKS'(1) << rd_bank : '0;

    // Simultaneous commit and release leave the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank      <= '0;
            rd_bank      <= '0;
            wr_addr      <= '0;
            rd_addr      <= '0;
            rd_pass      <= '0;
            fill_count   <= '0;
            wr_bank_done <= 1'b0;
            rd_bank_done <= 1'b0;
        end else begin
            wr_bank_done <= commit;
            rd_bank_done <= rel;
            if (wr_fire) wr_addr <= commit ? '0 : wr_addr + 1'b1;
            if (commit) wr_bank <= wr_bank == LAST_BANK ? '0 : wr_bank + 1'b1;
            if (rd_fire) rd_addr <= rd_wrap ? '0 : rd_addr + 1'b1;
            if (rd_wrap) rd_pass <= rel ? '0 : rd_pass + 1'b1;
            if (rel) rd_bank <= rd_bank == LAST_BANK ? '0 : rd_bank + 1'b1;
            if (commit != rel) fill_count <= commit ? fill_count + 1'b1 : fill_count - 1'b1;
        end
    end
endmodule

// File: tb/tb_multi_bank_buffer_control.sv
// tb_multi_bank_buffer_control: random producer/consumer traffic scored against
// a bank-queue reference model; a monitor pops expectations each cycle.
module tb_multi_bank_buffer_control;
    localparam int NB = 3;
    localparam int BW = 2;
    localparam int AW = 3;
    localparam int D  = 5;
    localparam int P  = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           wr_valid = 1'b0;
    logic           rd_req = 1'b0;
    logic           wr_ready, rd_valid, wr_bank_done, rd_bank_done;
    logic [NB-1:0]  wr_en, rd_en;
    logic [BW-1:0]  wr_bank, rd_bank;
    logic [AW-1:0]  wr_addr, rd_addr;
    logic [BW+AW-1:0] rd_pass;
    logic [BW:0]    fill_count;

    multi_bank_buffer_control #(
        .NUM_BANKS(NB), .BANK_W(BW), .ADDR_SIZE(AW), .DEPTH(D), .RD_PASSES(P)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_en(wr_en),
        .wr_bank(wr_bank), .wr_addr(wr_addr),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_en(rd_en),
        .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_pass(rd_pass),
        .fill_count(fill_count),
        .wr_bank_done(wr_bank_done), .rd_bank_done(rd_bank_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit in_rst, wready, rvalid, wfire, rfire, wd, rd;
        int fill, wb, rb;
    } st_t;
    typedef struct { int bank, addr, pass; } beat_t;

    st_t   st_q[$];
    beat_t wq[$];
    beat_t rq_q[$];
    int total = 0;
    int bad = 0;

    // Reference model: queue of committed banks, beat counters per bank.
    int filled[$];
    int wb = 0, wcnt = 0, rcnt = 0;
    bit wdone = 0, rdone = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit wv, input bit rq);
        st_t s;
        int sz;
        @(posedge clk);
        #1;
        rst = r;
        wr_valid = wv;
        rd_req = rq;
        sz = filled.size();
        s.in_rst = r;
        s.wready = !r && sz < NB;
        s.rvalid = !r && sz > 0;
        s.wfire  = wv && s.wready;
        s.rfire  = rq && s.rvalid;
        s.fill   = sz;
        s.wb     = wb;
        s.rb     = sz > 0 ? filled[0] : wb;
        s.wd     = wdone;
        s.rd     = rdone;
        st_q.push_back(s);
        if (r) begin
            filled.delete();
            wb = 0; wcnt = 0; rcnt = 0; wdone = 0; rdone = 0;
            return;
        end
        if (s.wfire) wq.push_back('{wb, wcnt, 0});
        if (s.rfire) rq_q.push_back('{filled[0], rcnt % D, rcnt / D});
        wdone = s.wfire && wcnt == D - 1;
        rdone = s.rfire && rcnt == D * P - 1;
        if (s.rfire) begin
            rcnt++;
            if (rcnt == D * P) begin
                rcnt = 0;
                void'(filled.pop_front());
            end
        end
        if (s.wfire) begin
            wcnt++;
            if (wcnt == D) begin
                wcnt = 0;
                filled.push_back(wb);
                wb = (wb + 1) % NB;
            end
        end
    endtask

    task automatic run(input int n, input int pw, input int pr);
        for (int i = 0; i < n; i++)
            cycle(0, $urandom_range(99) < pw, $urandom_range(99) < pr);
    endtask

    initial begin : mon
        st_t s;
        beat_t b;
        forever begin
            @(negedge clk);
            if (st_q.size() != 0) begin
                s = st_q.pop_front();
                chk("wr_ready", wr_ready, s.wready);
                chk("rd_valid", rd_valid, s.rvalid);
                chk("wr_en_active", wr_en != '0, s.wfire);
                chk("rd_en_active", rd_en != '0, s.rfire);
                if (!s.in_rst) begin
                    chk("fill_count", fill_count, s.fill);
                    chk("wr_bank", wr_bank, s.wb);
                    chk("rd_bank", rd_bank, s.rb);
                    chk("wr_bank_done", wr_bank_done, s.wd);
                    chk("rd_bank_done", rd_bank_done, s.rd);
                end
                if (wr_en != '0) begin
                    if (wq.size() == 0) chk("wr_beat_queued", 0, 1);
                    else begin
                        b = wq.pop_front();
                        chk("wr_en", wr_en, 1 << b.bank);
                        chk("wr_addr", wr_addr, b.addr);
                    end
                end
                if (rd_en != '0) begin
                    if (rq_q.size() == 0) chk("rd_beat_queued", 0, 1);
                    else begin
                        b = rq_q.pop_front();
                        chk("rd_en", rd_en, 1 << b.bank);
                        chk("rd_addr", rd_addr, b.addr);
                        chk("rd_pass", rd_pass, b.pass);
                    end
                end
                if (wr_en != '0 && rd_en != '0) chk("banks_distinct", wr_bank != rd_bank, 1);
            end
        end
    end

    initial begin
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        run(30, 100, 0);
        run(40, 0, 100);
        run(100, 100, 100);
        run(400, 50, 50);
        run(300, 80, 30);
        run(300, 30, 80);
        run(23, 90, 10);
        cycle(1, $urandom_range(1), $urandom_range(1));
        run(200, 60, 60);
        run(60, 100, 0);
        cycle(1, 1, 1);
        run(100, 70, 50);
        repeat (2) @(posedge clk);
        chk("wr_q_drained", wq.size(), 0);
        chk("rd_q_drained", rq_q.size(), 0);
        chk("st_q_drained", st_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
